cla_addsub_seq: RTL and testbench

Parametrised, multi-cycle carry-lookahead adder/subtractor and successor to the fixed 4-bit cla_adder.
- Processes a WIDTH-bit operation as WIDTH/BLOCK slices, one BLOCK-bit CLA slice per clock, with the carry registered between slices.
- Adds a subtract mode plus overflow and zero flags.
- Keeps the en/ready handshake so the datapath controller can issue back-to-back operations.

---
 rtl/cla_pkg.sv | 14 +
 rtl/cla_block.sv | 49 ++++
 rtl/cla_addsub_seq.sv | 145 ++++++++++++++
 tb/tb_cla_addsub_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequential CLA adder/subtractor.
package cla_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cla_state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_block.sv
// BLOCK-bit combinational carry-lookahead slice built from generate/propagate terms.
module cla_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             c_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   carry;
    logic             term;
    logic             c_acc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each carry is a flat sum of products of g/p terms and the slice carry-in.
    always_comb begin
        carry    = '0;
        term     = 1'b0;
        c_acc    = 1'b0;
        carry[0] = c_i;
        for (int i = 0; i < int'(BLOCK); i++) begin
            c_acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c_acc = c_acc | term;
            end
            term = c_i;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            carry[i+1] = c_acc | term;
        end
    end

    assign sum_o   = p ^ carry[BLOCK-1:0];
    assign cout_o  = carry[BLOCK];
    assign c_msb_o = carry[BLOCK-1];

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle adder/subtractor: one BLOCK-bit CLA slice per clock, carry held between slices.
module cla_addsub_seq
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] Output,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / BLOCK;
    localparam int unsigned CW     = cnt_width(NSLICE);

    cla_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [BLOCK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_c_msb;
    logic [WIDTH-1:0] acc_shift;

    cla_block #(
        .BLOCK (BLOCK)
    ) u_cla_block (
        .a_i     (a_q[BLOCK-1:0]),
        .b_i     (b_q[BLOCK-1:0]),
        .c_i     (carry_q),
        .sum_o   (slice_sum),
        .cout_o  (slice_cout),
        .c_msb_o (slice_c_msb)
    );

    // New slice enters at the MSB end; after NSLICE shifts the register holds the full sum.
    assign acc_shift = WIDTH'({slice_sum, acc_q} >> BLOCK);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        out_d   = out_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : c_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> BLOCK;
                b_d     = b_q >> BLOCK;
                carry_d = slice_cout;
                acc_d   = acc_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NSLICE - 1)) begin
                    out_d   = acc_shift;
                    c_out_d = slice_cout;
                    ovf_d   = slice_c_msb ^ slice_cout;
                    zero_d  = (acc_shift == '0);
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign Output   = out_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Scoreboard bench for cla_addsub_seq: 16/4 main instance plus 8/8 and 12/4 builds.
module tb_cla_addsub_seq;

    typedef struct packed {
        logic [15:0] out;
        logic        c;
        logic        ovf;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        en, sub, c_in;
    logic [15:0] A, B, Output;
    logic        busy, ready, c_out, overflow, zero;

    logic        en8, sub8, cin8;
    logic [7:0]  a8, b8, out8;
    logic        busy8, ready8, c8, ovf8, z8;

    logic        en12, sub12, cin12;
    logic [11:0] a12, b12, out12;
    logic        busy12, ready12, c12, ovf12, z12;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   n_push;
    int   n_ready;

    cla_addsub_seq #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sub(sub), .c_in(c_in), .A(A), .B(B),
        .busy(busy), .ready(ready), .Output(Output), .c_out(c_out),
        .overflow(overflow), .zero(zero)
    );

    cla_addsub_seq #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .sub(sub8), .c_in(cin8), .A(a8), .B(b8),
        .busy(busy8), .ready(ready8), .Output(out8), .c_out(c8),
        .overflow(ovf8), .zero(z8)
    );

    cla_addsub_seq #(.WIDTH(12), .BLOCK(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .en(en12), .sub(sub12), .c_in(cin12), .A(a12), .B(b12),
        .busy(busy12), .ready(ready12), .Output(out12), .c_out(c12),
        .overflow(ovf12), .zero(z12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from a plain wide addition.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic ci);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] r;
        bb    = s ? ~b : b;
        r     = {1'b0, a} + {1'b0, bb} + 17'(s ? 1'b1 : ci);
        e.out = r[15:0];
        e.c   = r[16];
        e.ovf = (a[15] == bb[15]) && (r[15] != a[15]);
        e.z   = (r[15:0] == 16'h0000);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop and compare whenever the main instance completes.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            exp_t e;
            n_ready++;
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_ready: observed Output %h with empty scoreboard", Output);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("result", 32'({Output, c_out, overflow, zero}), 32'(e));
            end
        end
    end

    // Drive one request; returns just after the accepting edge with inputs scrambled.
    task automatic accept16(input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic ci, input bit push);
        en = 1'b1; A = a; B = b; sub = s; c_in = ci;
        if (push) begin
            sb.push_back(model(a, b, s, ci));
            n_push++;
        end
        @(posedge clk); #1;
        en   = 1'b0;
        A    = 16'($urandom);
        B    = 16'($urandom);
        sub  = 1'($urandom);
        c_in = 1'($urandom);
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full operation with latency and busy-width checks; returns in the ready cycle.
    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic ci, input string tag);
        int lat;
        int nb;
        accept16(a, b, s, ci, 1'b1);
        nb  = (busy === 1'b1) ? 1 : 0;
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) nb++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_busy"}, 32'(nb), 32'd4);
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_bad = 0; n_push = 0; n_ready = 0;
        rst_n = 1'b0;
        en = 1'b0; sub = 1'b0; c_in = 1'b0; A = '0; B = '0;
        en8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        en12 = 1'b0; sub12 = 1'b0; cin12 = 1'b0; a12 = '0; b12 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_16", 32'({busy, ready, Output, c_out, overflow, zero}), 32'd0);
        check("rst_8",  32'({busy8, ready8, out8, c8, ovf8, z8}), 32'd0);
        check("rst_12", 32'({busy12, ready12, out12, c12, ovf12, z12}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add, then ready must drop and the result must hold.
        run16(16'h0001, 16'h0002, 1'b0, 1'b0, "t1");
        check("t1_res", 32'({Output, c_out, overflow, zero}), 32'({16'h0003, 3'b000}));
        @(posedge clk); #1;
        check("t1_ready_drop", 32'(ready), 32'd0);
        check("t1_hold", 32'(Output), 32'h0003);

        // Carry-out / zero, then signed overflow.
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "t2a");
        check("t2a_res", 32'({Output, c_out, overflow, zero}), 32'({16'h0000, 3'b101}));
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "t2b");
        check("t2b_res", 32'({Output, c_out, overflow, zero}), 32'({16'h8000, 3'b010}));

        // Subtract: c_in ignored, borrow and overflow cases.
        run16(16'h0005, 16'h0007, 1'b1, 1'b1, "t3a");
        check("t3a_res", 32'({Output, c_out, overflow, zero}), 32'({16'hFFFE, 3'b000}));
        run16(16'h8000, 16'h0001, 1'b1, 1'b0, "t3b");
        check("t3b_res", 32'({Output, c_out, overflow, zero}), 32'({16'h7FFF, 3'b110}));

        // en while busy is ignored; en in the ready cycle is accepted.
        accept16(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        en = 1'b1; A = 16'h0009; B = 16'h0009; sub = 1'b0; c_in = 1'b0;
        check("t4_busy_at_en", 32'(busy), 32'd1);
        @(posedge clk); #1;
        en = 1'b0;
        wait_ready(lat);
        check("t4_first_lat", 32'(lat), 32'd2);
        check("t4_first_res", 32'(Output), 32'h0003);
        accept16(16'h0004, 16'h0004, 1'b0, 1'b0, 1'b1);
        wait_ready(lat);
        check("t4_second_lat", 32'(lat), 32'd4);
        check("t4_second_res", 32'(Output), 32'h0008);
        @(posedge clk); #1;
        check("t4_idle_after", 32'({busy, ready}), 32'd0);

        // Reset mid-operation aborts silently and clears outputs.
        accept16(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out", 32'({busy, ready, Output, c_out, overflow, zero}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_ready", 32'({busy, ready}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run16(16'h0010, 16'h0020, 1'b0, 1'b0, "t5");
        check("t5_res", 32'(Output), 32'h0030);

        // Back-to-back random operations against the model.
        for (int i = 0; i < 8; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rnd");
        end
        @(posedge clk); #1;

        // Single-slice build: one-cycle latency.
        en8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0;
        @(posedge clk); #1;
        en8 = 1'b0;
        lat = 0;
        while (ready8 !== 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check("w8_lat", 32'(lat), 32'd1);
        check("w8_res", 32'({out8, c8, ovf8, z8}), 32'({8'h00, 3'b101}));
        en8 = 1'b1; a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1; cin8 = 1'b0;
        @(posedge clk); #1;
        en8 = 1'b0;
        lat = 0;
        while (ready8 !== 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check("w8_sub_lat", 32'(lat), 32'd1);
        check("w8_sub_res", 32'({out8, c8, ovf8, z8}), 32'({8'h7F, 3'b110}));

        // Three-slice build.
        en12 = 1'b1; a12 = 12'hFFF; b12 = 12'h001; sub12 = 1'b0; cin12 = 1'b0;
        @(posedge clk); #1;
        en12 = 1'b0;
        lat = 0;
        while (ready12 !== 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check("w12_lat", 32'(lat), 32'd3);
        check("w12_res", 32'({out12, c12, ovf12, z12}), 32'({12'h000, 3'b101}));

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("ready_count", 32'(n_ready), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
